// File: rtl/alu_seq.sv
// Datapath ALU with bus-loaded A/B operands, registered result and {Z,N,C,V} flags.
// Latency: single-cycle ops commit at the en_r edge; MUL commits WIDTH edges after start, shifts max(n,1).
// Backpressure: busy is high while an iterative op runs; en_r during busy is dropped, done pulses on commit.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             sync_reset_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             en_a,
  input  logic             en_b,
  input  logic             en_r,
  input  logic [3:0]       func_sel,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ZERO  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_PASSA = 4'b0110;
  localparam logic [3:0] OP_NOTA  = 4'b0111;
  localparam logic [3:0] OP_ADC   = 4'b1000;
  localparam logic [3:0] OP_SBB   = 4'b1001;
  localparam logic [3:0] OP_SHL   = 4'b1010;
  localparam logic [3:0] OP_SHR   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_CMP   = 4'b1101;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_result;
  logic [3:0]         r_flags;
  logic               r_done;

  // Working copies latched at start so operand reloads during RUN are harmless
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_wa;
  logic [2*WIDTH-1:0] r_prod;      // {partial high half, remaining multiplier bits}
  logic [WIDTH-1:0]   r_sh;
  logic               r_shn;       // shift count was nonzero
  logic [CW-1:0]      r_cnt;       // iterations left after the current one

  logic               w_is_multi, w_start, w_single, w_last;
  logic [CW-1:0]      w_cnt_load;

  logic               w_ci;
  logic [WIDTH:0]     w_add_u, w_sub_u;
  logic [WIDTH-1:0]   w_val;
  logic               w_c, w_v, w_wr_res;

  logic [WIDTH:0]     w_mac;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic               w_sh_out;
  logic [WIDTH-1:0]   w_mv;
  logic               w_mc;

  assign result = r_result;
  assign flags  = r_flags;
  assign busy   = (r_state == S_RUN);
  assign done   = r_done;

  assign w_is_multi = (func_sel == OP_SHL) || (func_sel == OP_SHR) || (func_sel == OP_MUL);
  assign w_start    = (r_state == S_IDLE) && en_r && w_is_multi;
  assign w_single   = (r_state == S_IDLE) && en_r && !w_is_multi;
  assign w_last     = (r_state == S_RUN) && (r_cnt == '0);
  assign w_cnt_load = (func_sel == OP_MUL)       ? CW'(WIDTH-1) :
                      (r_b[CW-1:0] == '0)        ? '0 :
                                                   (r_b[CW-1:0] - CW'(1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!sync_reset_n) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // FSM next state: IDLE->RUN on an iterative start, RUN->IDLE on the final iteration
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ALU: value, carry/borrow and signed overflow from the current A/B
  always_comb begin
    w_ci     = ((func_sel == OP_ADC) || (func_sel == OP_SBB)) ? r_flags[1] : 1'b0;
    w_add_u  = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_ci};
    w_sub_u  = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, w_ci};
    w_val    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_wr_res = 1'b1;
    case (func_sel)
      OP_ADD, OP_ADC: begin
        w_val = w_add_u[WIDTH-1:0];
        w_c   = w_add_u[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_val[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        w_val    = w_sub_u[WIDTH-1:0];
        w_c      = w_sub_u[WIDTH];
        w_v      = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_val[WIDTH-1] != r_a[WIDTH-1]);
        w_wr_res = (func_sel != OP_CMP);
      end
      OP_XOR:   w_val = r_a ^ r_b;
      OP_AND:   w_val = r_a & r_b;
      OP_OR:    w_val = r_a | r_b;
      OP_PASSA: w_val = r_a;
      OP_NOTA:  w_val = ~r_a;
      default:  w_val = '0;
    endcase
  end

  // One iteration of shift-and-add multiply or single-bit shift, plus the commit value
  always_comb begin
    w_mac      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_wa} : '0);
    w_prod_nxt = {w_mac, r_prod[WIDTH-1:1]};
    w_sh_nxt   = r_sh;
    w_sh_out   = 1'b0;
    if (r_shn) begin
      if (r_op == OP_SHL) begin
        w_sh_nxt = {r_sh[WIDTH-2:0], 1'b0};
        w_sh_out = r_sh[WIDTH-1];
      end else begin
        w_sh_nxt = {1'b0, r_sh[WIDTH-1:1]};
        w_sh_out = r_sh[0];
      end
    end
    if (r_op == OP_MUL) begin
      w_mv = w_prod_nxt[WIDTH-1:0];
      w_mc = |w_prod_nxt[2*WIDTH-1:WIDTH];
    end else begin
      w_mv = w_sh_nxt;
      w_mc = w_sh_out;
    end
  end

  // Operand loads, single-cycle commits, iterative working state and final commit
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
      r_op     <= OP_ZERO;
      r_wa     <= '0;
      r_prod   <= '0;
      r_sh     <= '0;
      r_shn    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (en_a) r_a <= bus;
      if (en_b) r_b <= bus;
      r_done <= w_last;
      if (w_single) begin
        if (w_wr_res) r_result <= w_val;
        r_flags <= {(w_val == '0), w_val[WIDTH-1], w_c, w_v};
      end
      if (w_start) begin
        r_op   <= func_sel;
        r_wa   <= r_a;
        r_prod <= {{WIDTH{1'b0}}, r_b};
        r_sh   <= r_a;
        r_shn  <= |r_b[CW-1:0];
        r_cnt  <= w_cnt_load;
      end
      if (r_state == S_RUN) begin
        r_prod <= w_prod_nxt;
        r_sh   <= w_sh_nxt;
        r_cnt  <= r_cnt - CW'(1);
        if (w_last) begin
          r_result <= w_mv;
          r_flags  <= {(w_mv == '0), w_mv[WIDTH-1], w_mc, 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed table, corner sequences, random vs model.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Every multi-cycle wait is bounded; an expired bound is reported as a failed comparison.
module tb_alu_seq;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         sync_reset_n;
  logic [W-1:0] bus;
  logic         en_a, en_b, en_r;
  logic [3:0]   func_sel;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy, done;

  int n_chk = 0;
  int n_fail = 0;

  // Architectural state as the bench believes it to be
  int       m_a, m_b, m_r;
  logic [3:0] m_f;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] er;
    logic [3:0] ef;
    int         lat;
  } vec_t;
  vec_t tbl[20];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .sync_reset_n(sync_reset_n), .bus(bus), .en_a(en_a), .en_b(en_b),
    .en_r(en_r), .func_sel(func_sel), .result(result), .flags(flags),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sgn(input int x);
    return (x >= (1 << (W-1))) ? x - (1 << W) : x;
  endfunction

  // Reference: {result, Z, N, C, V} from the operation rules using plain integer arithmetic
  function automatic logic [W+3:0] ref_op(input logic [3:0] op, input int a, input int b,
                                         input bit cin, input int prev);
    int t, st, val, res, n;
    bit c, v;
    c = 0; v = 0; val = 0;
    n = b % W;
    case (op)
      4'd1, 4'd8: begin
        t  = a + b + ((op == 4'd8) ? int'(cin) : 0);
        st = sgn(a) + sgn(b) + ((op == 4'd8) ? int'(cin) : 0);
        val = t & MASK; c = (t > MASK); v = (st > MASK/2) || (st < -(MASK/2) - 1);
      end
      4'd2, 4'd9, 4'd13: begin
        t  = a - b - ((op == 4'd9) ? int'(cin) : 0);
        st = sgn(a) - sgn(b) - ((op == 4'd9) ? int'(cin) : 0);
        val = t & MASK; c = (t < 0); v = (st > MASK/2) || (st < -(MASK/2) - 1);
      end
      4'd3: val = a ^ b;
      4'd4: val = a & b;
      4'd5: val = a | b;
      4'd6: val = a;
      4'd7: val = (~a) & MASK;
      4'd10: begin
        if (n == 0) val = a;
        else begin val = (a << n) & MASK; c = ((a >> (W - n)) & 1) != 0; end
      end
      4'd11: begin
        if (n == 0) val = a;
        else begin val = a >> n; c = ((a >> (n - 1)) & 1) != 0; end
      end
      4'd12: begin
        t = a * b; val = t & MASK; c = (t >> W) != 0;
      end
      default: val = 0;
    endcase
    res = (op == 4'd13) ? prev : val;
    return {res[W-1:0], (val == 0), val[W-1], c, v};
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input int b);
    if (op == 4'd12) return W;
    if (op == 4'd10 || op == 4'd11) return ((b % W) == 0) ? 1 : (b % W);
    return 0;
  endfunction

  // Load A and B, issue the op, then check latency, handshake and committed values
  task automatic exec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] ef, input int lat, input string tag);
    int n;
    bus = a; en_a = 1'b1; tick; en_a = 1'b0;
    bus = b; en_b = 1'b1; tick; en_b = 1'b0;
    func_sel = op; en_r = 1'b1; tick; en_r = 1'b0;
    if (lat == 0) begin
      check({tag, ".result"}, 32'(result), 32'(er));
      check({tag, ".flags"},  32'(flags),  32'(ef));
      check({tag, ".busy"},   32'(busy),   32'd0);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 200) begin
        check({tag, ".no_done_while_busy"}, 32'(done), 32'd0);
        n++; tick;
      end
      check({tag, ".busy_cycles"}, 32'(n), 32'(lat));
      check({tag, ".done"},   32'(done),   32'd1);
      check({tag, ".result"}, 32'(result), 32'(er));
      check({tag, ".flags"},  32'(flags),  32'(ef));
      tick;
      check({tag, ".done_pulse"}, 32'(done), 32'd0);
    end
    m_a = a; m_b = b; m_r = er; m_f = ef;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+3:0] e;
    logic [3:0]   op;
    int           ra, rb, n;

    tbl[0]  = '{4'h1, 8'h7F, 8'h01, 8'h80, 4'b0101, 0};  // ADD signed overflow
    tbl[1]  = '{4'h1, 8'hF0, 8'h20, 8'h10, 4'b0010, 0};  // ADD carry
    tbl[2]  = '{4'h8, 8'hFF, 8'h00, 8'h00, 4'b1010, 0};  // ADC with C=1
    tbl[3]  = '{4'h9, 8'h10, 8'h05, 8'h0A, 4'b0000, 0};  // SBB with C=1
    tbl[4]  = '{4'h2, 8'h05, 8'h07, 8'hFE, 4'b0110, 0};  // SUB borrow
    tbl[5]  = '{4'hD, 8'h33, 8'h33, 8'hFE, 4'b1000, 0};  // CMP equal, result holds
    tbl[6]  = '{4'h3, 8'h5A, 8'hFF, 8'hA5, 4'b0100, 0};
    tbl[7]  = '{4'h4, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0};
    tbl[8]  = '{4'h5, 8'h0F, 8'h30, 8'h3F, 4'b0000, 0};
    tbl[9]  = '{4'h7, 8'h0F, 8'h55, 8'hF0, 4'b0100, 0};
    tbl[10] = '{4'h6, 8'h00, 8'h12, 8'h00, 4'b1000, 0};
    tbl[11] = '{4'hE, 8'h12, 8'h34, 8'h00, 4'b1000, 0};  // reserved code acts as ZERO
    tbl[12] = '{4'hC, 8'h0D, 8'h0B, 8'h8F, 4'b0100, 8};
    tbl[13] = '{4'hC, 8'h20, 8'h10, 8'h00, 4'b1010, 8};  // product only in high half
    tbl[14] = '{4'hB, 8'h81, 8'h01, 8'h40, 4'b0010, 1};
    tbl[15] = '{4'hA, 8'h81, 8'h03, 8'h08, 4'b0000, 3};
    tbl[16] = '{4'hA, 8'h81, 8'h00, 8'h81, 4'b0100, 1};  // zero count still takes one cycle
    tbl[17] = '{4'hB, 8'h81, 8'h07, 8'h01, 4'b0000, 7};
    tbl[18] = '{4'hD, 8'h05, 8'h07, 8'h01, 4'b0110, 0};  // CMP borrow, result holds
    tbl[19] = '{4'h1, 8'h80, 8'h80, 8'h00, 4'b1011, 0};

    // Reset with operand loads and a start request asserted: all must be ignored
    sync_reset_n = 1'b0; bus = 8'hFF; en_a = 1'b1; en_b = 1'b0; en_r = 1'b1; func_sel = 4'hC;
    tick;
    en_a = 1'b0; en_b = 1'b1;
    tick;
    en_b = 1'b0; en_r = 1'b0;
    check("reset.result", 32'(result), 32'd0);
    check("reset.flags",  32'(flags),  32'd0);
    check("reset.busy",   32'(busy),   32'd0);
    check("reset.done",   32'(done),   32'd0);
    sync_reset_n = 1'b1;
    func_sel = 4'h1; en_r = 1'b1; tick; en_r = 1'b0;
    check("reset.add_cleared_ops.result", 32'(result), 32'd0);
    check("reset.add_cleared_ops.flags",  32'(flags),  32'b1000);
    m_r = 0; m_f = 4'b1000;

    for (int i = 0; i < 20; i++)
      exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].er, tbl[i].ef, tbl[i].lat, $sformatf("tbl%0d", i));

    // MUL with en_a reload and en_r/func_sel change mid-run: product must be unaffected
    bus = 8'h0D; en_a = 1'b1; tick; en_a = 1'b0;
    bus = 8'h0B; en_b = 1'b1; tick; en_b = 1'b0;
    func_sel = 4'hC; en_r = 1'b1; tick; en_r = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 2) begin bus = 8'hFF; en_a = 1'b1; en_r = 1'b1; func_sel = 4'h1; end
      else begin en_a = 1'b0; en_r = 1'b0; end
      n++; tick;
    end
    en_a = 1'b0; en_r = 1'b0;
    check("mulint.busy_cycles", 32'(n), 32'd8);
    check("mulint.done",   32'(done),   32'd1);
    check("mulint.result", 32'(result), 32'h8F);
    check("mulint.flags",  32'(flags),  32'b0100);
    tick;
    check("mulint.done_pulse", 32'(done), 32'd0);

    // New en_r accepted in the done cycle
    bus = 8'h81; en_a = 1'b1; tick; en_a = 1'b0;
    bus = 8'h01; en_b = 1'b1; tick; en_b = 1'b0;
    func_sel = 4'hB; en_r = 1'b1; tick; en_r = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; tick; end
    check("donecyc.done", 32'(done), 32'd1);
    check("donecyc.shr_result", 32'(result), 32'h40);
    func_sel = 4'h1; en_r = 1'b1; tick; en_r = 1'b0;
    check("donecyc.add_result", 32'(result), 32'h82);
    check("donecyc.add_flags",  32'(flags),  32'b0100);
    check("donecyc.busy",       32'(busy),   32'd0);
    m_a = 8'h81; m_b = 8'h01; m_r = 8'h82; m_f = 4'b0100;

    // Reset in the 4th RUN cycle of a MUL aborts it without a done pulse
    bus = 8'h0D; en_a = 1'b1; tick; en_a = 1'b0;
    bus = 8'h0B; en_b = 1'b1; tick; en_b = 1'b0;
    func_sel = 4'hC; en_r = 1'b1; tick; en_r = 1'b0;
    tick; tick; tick;
    check("abort.busy_before", 32'(busy), 32'd1);
    sync_reset_n = 1'b0; tick; sync_reset_n = 1'b1;
    check("abort.busy",   32'(busy),   32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.flags",  32'(flags),  32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) n++;
      tick;
    end
    check("abort.no_done", 32'(n), 32'd0);
    m_r = 0; m_f = 4'b0000;
    exec(4'h1, 8'h03, 8'h04, 8'h07, 4'b0000, 0, "abort.add_after");

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = int'($urandom_range(0, MASK));
      rb = int'($urandom_range(0, MASK));
      e  = ref_op(op, ra, rb, m_f[1], m_r);
      exec(op, 8'(ra), 8'(rb), e[W+3:4], e[3:0], ref_lat(op, rb), $sformatf("rnd%0d_op%0h", i, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
